// File: rtl/metro_gate_scheduler_pkg.sv
// metro_pkg
// Shared definitions for the metro gate scheduler slice:
//   - state_t        : scheduler FSM encoding, also exported to station monitoring
//   - CODE_W         : width of one lane's access code
//   - GRANT_W        : width of the exported lane index
//   - DEF_CODE_LO/HI : default inclusive window of accepted access codes
//   - code_in_window : unsigned inclusive window test used by the CHECK state
package metro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    OPEN  = 2'b10,
    CLOSE = 2'b11
  } state_t;

  localparam int CODE_W  = 4;
  localparam int GRANT_W = 3;

  localparam logic [CODE_W-1:0] DEF_CODE_LO = 4'd4;
  localparam logic [CODE_W-1:0] DEF_CODE_HI = 4'd11;

  // An access code is accepted when it lies inside [lo, hi], compared unsigned.
  function automatic logic code_in_window(input logic [CODE_W-1:0] code,
                                          input logic [CODE_W-1:0] lo,
                                          input logic [CODE_W-1:0] hi);
    return (code >= lo) && (code <= hi);
  endfunction

endpackage

// File: rtl/metro_gate_scheduler_if.sv
// metro_gate_scheduler_if
// Bundle between the per-lane card readers / door actuators and the scheduler.
//   lane_req   : per-lane request, held by the reader until lane_ack
//   lane_code  : 4-bit access code per lane, lane k at [4k+3:4k]
//   lane_ack   : one-cycle pulse, request captured
//   lane_deny  : one-cycle pulse, code rejected
//   door_open  : door drive, at most one bit high
//   grant_idx  : lane currently or last served
//   state_out  : scheduler FSM state for station monitoring
// Modports: master = lane/reader side, slave = scheduler side.
interface metro_gate_scheduler_if #(
  parameter int NUM_LANES = 4
);
  import metro_pkg::*;

  logic [NUM_LANES-1:0]        lane_req;
  logic [CODE_W*NUM_LANES-1:0] lane_code;
  logic [NUM_LANES-1:0]        lane_ack;
  logic [NUM_LANES-1:0]        lane_deny;
  logic [NUM_LANES-1:0]        door_open;
  logic [GRANT_W-1:0]          grant_idx;
  logic [1:0]                  state_out;

  modport master (
    output lane_req, lane_code,
    input  lane_ack, lane_deny, door_open, grant_idx, state_out
  );

  modport slave (
    input  lane_req, lane_code,
    output lane_ack, lane_deny, door_open, grant_idx, state_out
  );

endinterface

// File: rtl/metro_gate_scheduler_rr_arbiter.sv
// metro_rr_arbiter
// Purely combinational round-robin pick among the eligible lanes.
//   req          : eligible request vector
//   ptr          : lane index where the search starts (held by the parent)
//   grant_onehot : one-hot of the chosen lane, zero when nothing is eligible
//   grant_idx    : index of the chosen lane
//   any_grant    : some lane was chosen
module metro_rr_arbiter
  import metro_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [GRANT_W-1:0]   ptr,
  output logic [NUM_LANES-1:0] grant_onehot,
  output logic [GRANT_W-1:0]   grant_idx,
  output logic                 any_grant
);

  // Walk the lanes starting at ptr and wrapping past the top; the first
  // requesting lane found wins, so the lane just after the last winner
  // always has the highest priority.
  always_comb begin
    int cand;
    grant_onehot = '0;
    grant_idx    = '0;
    any_grant    = 1'b0;
    cand         = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_LANES) begin
        cand = cand - NUM_LANES;
      end
      if (!any_grant && req[cand]) begin
        any_grant          = 1'b1;
        grant_onehot[cand] = 1'b1;
        grant_idx          = GRANT_W'(cand);
      end
    end
  end

endmodule

// File: rtl/metro_gate_scheduler.sv
// metro_gate_scheduler
// Shares one access-code check and door timer among NUM_LANES turnstile
// lanes. A lane is picked round-robin in IDLE, its code is checked in CHECK,
// and the door is then held open for OPEN_CYCLES cycles followed by one
// CLOSE guard cycle; a rejected code returns straight to IDLE with a deny.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, closes any door immediately
//   bus : metro_gate_scheduler_if.slave (requests, codes, ack/deny pulses,
//         door drive, grant index and exported state)
// Optional feature: define METRO_LOCKOUT_EN to lock a lane out for
// LOCKOUT_CYCLES cycles after its third consecutive denial.
module metro_gate_scheduler
  import metro_pkg::*;
#(
  parameter int                NUM_LANES      = 4,
  parameter int                OPEN_CYCLES    = 15,
  parameter logic [CODE_W-1:0] CODE_LO        = DEF_CODE_LO,
  parameter logic [CODE_W-1:0] CODE_HI        = DEF_CODE_HI,
  parameter int                LOCKOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  metro_gate_scheduler_if.slave bus
);

  localparam int TIMER_W = $clog2(OPEN_CYCLES + 1);

  state_t                 state;
  logic [GRANT_W-1:0]     ptr;
  logic [GRANT_W-1:0]     grant_q;
  logic [NUM_LANES-1:0]   gnt_q;
  logic [NUM_LANES-1:0]   ack_q;
  logic [NUM_LANES-1:0]   deny_q;
  logic [NUM_LANES-1:0]   door_q;
  logic [CODE_W-1:0]      code_q;
  logic [TIMER_W-1:0]     timer;

  logic [NUM_LANES-1:0]   eligible;
  logic [NUM_LANES-1:0]   arb_onehot;
  logic [GRANT_W-1:0]     arb_idx;
  logic                   arb_any;
  logic [GRANT_W-1:0]     ptr_next;
  logic [CODE_W-1:0]      sel_code;
  logic                   code_ok;

  assign code_ok  = code_in_window(code_q, CODE_LO, CODE_HI);
  assign ptr_next = (arb_idx == GRANT_W'(NUM_LANES - 1)) ? '0 : arb_idx + GRANT_W'(1);

`ifdef METRO_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  logic [1:0]           deny_cnt [NUM_LANES];
  logic [LOCK_W-1:0]    lock_tmr [NUM_LANES];
  logic [NUM_LANES-1:0] locked;

  // A lane whose lockout timer is still running is invisible to the arbiter,
  // so its held request is neither acked nor lost.
  always_comb begin
    locked = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      locked[k] = (lock_tmr[k] != '0);
    end
  end

  assign eligible = bus.lane_req & ~locked;

  // Per-lane consecutive-deny bookkeeping. The verdict for the lane under
  // CHECK is known this cycle, so counting happens on the same edge that
  // produces the deny pulse. The third deny in a row arms the lockout; the
  // counter stays at two until the lockout runs out and clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        deny_cnt[k] <= '0;
        lock_tmr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (lock_tmr[k] != '0) begin
          lock_tmr[k] <= lock_tmr[k] - LOCK_W'(1);
          if (lock_tmr[k] == LOCK_W'(1)) begin
            deny_cnt[k] <= '0;
          end
        end else if (state == CHECK && gnt_q[k]) begin
          if (code_ok) begin
            deny_cnt[k] <= '0;
          end else if (deny_cnt[k] == 2'd2) begin
            lock_tmr[k] <= LOCK_W'(LOCKOUT_CYCLES);
          end else begin
            deny_cnt[k] <= deny_cnt[k] + 2'd1;
          end
        end
      end
    end
  end
`else
  logic unused_lockout;

  // Without lockout every requesting lane competes; the lockout length is
  // kept only so both builds share one parameter list.
  assign eligible       = bus.lane_req;
  assign unused_lockout = |LOCKOUT_CYCLES;
`endif

  metro_rr_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_arb (
    .req          (eligible),
    .ptr          (ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .any_grant    (arb_any)
  );

  // Pick out the access code of whichever lane the arbiter chose so it can be
  // latched on the grant edge.
  always_comb begin
    sel_code = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (arb_onehot[k]) begin
        sel_code = bus.lane_code[k*CODE_W +: CODE_W];
      end
    end
  end

  // Scheduler FSM. Every output is a register so ack/deny/door change only on
  // clock edges (or immediately on reset). ack and deny default low each
  // cycle so they come out as single-cycle pulses. The door vector is copied
  // from the one-hot grant captured in IDLE, which keeps it one-hot by
  // construction. The open timer is loaded with OPEN_CYCLES-1 and the door
  // stays up through the cycle where it reads zero, giving exactly
  // OPEN_CYCLES open cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      deny_q  <= '0;
      door_q  <= '0;
      code_q  <= '0;
      timer   <= '0;
    end else begin
      ack_q  <= '0;
      deny_q <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            state   <= CHECK;
            grant_q <= arb_idx;
            gnt_q   <= arb_onehot;
            code_q  <= sel_code;
            ack_q   <= arb_onehot;
            ptr     <= ptr_next;
          end
        end
        CHECK: begin
          if (code_ok) begin
            state  <= OPEN;
            timer  <= TIMER_W'(OPEN_CYCLES - 1);
            door_q <= gnt_q;
          end else begin
            state  <= IDLE;
            deny_q <= gnt_q;
          end
        end
        OPEN: begin
          if (timer == '0) begin
            state  <= CLOSE;
            door_q <= '0;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end
        CLOSE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          door_q <= '0;
        end
      endcase
    end
  end

  assign bus.lane_ack  = ack_q;
  assign bus.lane_deny = deny_q;
  assign bus.door_open = door_q;
  assign bus.grant_idx = grant_q;
  assign bus.state_out = state;

endmodule

// File: tb/tb_metro_gate_scheduler.sv
// tb_metro_gate_scheduler
// Scoreboard bench for metro_gate_scheduler. Stimulus pushes the expected
// ack/deny/door events (with hand-computed cycle numbers) into a queue; a
// monitor turns DUT activity into events and compares them in order.
// The lockout scenario is included when METRO_LOCKOUT_EN is defined.
module tb_metro_gate_scheduler;

  localparam int NL      = 4;
  localparam int EV_ACK  = 0;
  localparam int EV_DENY = 1;
  localparam int EV_DOOR = 2;

  typedef struct {
    int kind;
    int lane;
    int cyc;
    int len;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  exp_t expq[$];

  int issued   [NL];
  int served   [NL];
  int start_at [NL];

  logic [3:0] t2_codes [4];
  logic       t2_opens [4];

  metro_gate_scheduler_if #(.NUM_LANES(NL)) bus ();

  metro_gate_scheduler #(
    .NUM_LANES      (NL),
    .OPEN_CYCLES    (15),
    .CODE_LO        (4'd4),
    .CODE_HI        (4'd11),
    .LOCKOUT_CYCLES (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle number; a value seen at a falling edge names the
  // cycle that began on the preceding rising edge.
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Watchdog so a stuck run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic void pushExp(input int kind, input int lane, input int c, input int len);
    exp_t e;
    e.kind = kind;
    e.lane = lane;
    e.cyc  = c;
    e.len  = len;
    expq.push_back(e);
  endfunction

  function automatic void checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endfunction

  function automatic void observe(input int kind, input int lane, input int c, input int len);
    exp_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL event_unexpected: got kind=%0d lane=%0d cyc=%0d len=%0d, want no event",
               kind, lane, c, len);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.lane != lane || e.cyc != c || e.len != len) begin
        errors++;
        $display("[TB] FAIL event: got kind=%0d lane=%0d cyc=%0d len=%0d, want kind=%0d lane=%0d cyc=%0d len=%0d",
                 kind, lane, c, len, e.kind, e.lane, e.cyc, e.len);
      end
    end
  endfunction

  // Lane readers: a lane holds its request while it has unserved requests
  // whose start cycle has come, and drops it on the edge ending the ack.
  initial begin
    bus.lane_req = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        if (bus.lane_ack[k]) served[k]++;
        bus.lane_req[k] = (issued[k] > served[k]) && (cyc >= start_at[k]);
      end
    end
  end

  // Monitor: converts ack/deny pulses and complete door-open intervals into
  // events for the scoreboard, and flags any cycle with two doors open.
  initial begin
    bit door_active;
    bit multi_hot;
    int door_lane;
    int door_start;
    int door_len;
    door_active = 1'b0;
    multi_hot   = 1'b0;
    door_lane   = 0;
    door_start  = 0;
    door_len    = 0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NL; k++) if (bus.lane_ack[k])  observe(EV_ACK, k, cyc, 0);
      for (int k = 0; k < NL; k++) if (bus.lane_deny[k]) observe(EV_DENY, k, cyc, 0);
      if (bus.door_open != '0) begin
        if ($countones(bus.door_open) > 1) multi_hot = 1'b1;
        if (!door_active) begin
          door_active = 1'b1;
          door_start  = cyc;
          door_len    = 1;
          for (int k = 0; k < NL; k++) if (bus.door_open[k]) door_lane = k;
        end else begin
          door_len++;
        end
      end else if (door_active) begin
        door_active = 1'b0;
        observe(EV_DOOR, door_lane, door_start, door_len);
        checkOutput("door_onehot", int'(multi_hot), 0);
        multi_hot = 1'b0;
      end
    end
  end

  task automatic stimSlot();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input int lane, input logic [3:0] code, input int count, input int delay);
    bus.lane_code[4*lane +: 4] = code;
    start_at[lane]             = cyc + delay;
    issued[lane]               = issued[lane] + count;
  endtask

  task automatic waitCycle(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  initial begin
    int t;
    t2_codes = '{4'd3, 4'd12, 4'd4, 4'd11};
    t2_opens = '{1'b0, 1'b0, 1'b1, 1'b1};
    checks = 0;
    errors = 0;
    for (int k = 0; k < NL; k++) begin
      issued[k]   = 0;
      served[k]   = 0;
      start_at[k] = 0;
    end
    bus.lane_code = '0;
    rst = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_state", int'(bus.state_out), 0);
    checkOutput("reset_door", int'(bus.door_open), 0);
    checkOutput("reset_grant_idx", int'(bus.grant_idx), 0);
    checkOutput("reset_ack", int'(bus.lane_ack), 0);
    rst = 1'b0;

    // Lane 2 alone, code 7
    $display("[TB] lane 2 alone, valid code");
    stimSlot();
    t = cyc;
    applyStimulus(2, 4'd7, 1, 0);
    pushExp(EV_ACK, 2, t + 1, 0);
    pushExp(EV_DOOR, 2, t + 2, 15);
    waitCycle(t + 1);
    checkOutput("t1_grant_idx", int'(bus.grant_idx), 2);
    waitCycle(t + 17);
    checkOutput("t1_close_state", int'(bus.state_out), 3);
    waitCycle(t + 18);
    checkOutput("t1_idle_state", int'(bus.state_out), 0);

    // Lane 0 boundary codes: 3 and 12 denied, 4 and 11 open
    $display("[TB] lane 0 code window boundaries");
    for (int i = 0; i < 4; i++) begin
      stimSlot();
      t = cyc;
      applyStimulus(0, t2_codes[i], 1, 0);
      pushExp(EV_ACK, 0, t + 1, 0);
      if (t2_opens[i]) begin
        pushExp(EV_DOOR, 0, t + 2, 15);
        waitCycle(t + 18);
      end else begin
        pushExp(EV_DENY, 0, t + 2, 0);
        waitCycle(t + 2);
        checkOutput("t2_deny_state", int'(bus.state_out), 0);
      end
    end

    // Reset mid-OPEN on lane 1
    $display("[TB] reset during open door");
    stimSlot();
    t = cyc;
    applyStimulus(1, 4'd7, 1, 0);
    pushExp(EV_ACK, 1, t + 1, 0);
    pushExp(EV_DOOR, 1, t + 2, 4);
    waitCycle(t + 5);
    checkOutput("t4_door_before_reset", int'(bus.door_open), 2);
    #2 rst = 1'b1;
    #1;
    checkOutput("t4_door_async", int'(bus.door_open), 0);
    checkOutput("t4_state_async", int'(bus.state_out), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t4_state_after", int'(bus.state_out), 0);
    checkOutput("t4_grant_after", int'(bus.grant_idx), 0);

    // All four lanes requesting, lane 0 twice: order 0,1,2,3,0
    $display("[TB] four lanes round robin");
    stimSlot();
    t = cyc;
    applyStimulus(0, 4'd4, 2, 0);
    applyStimulus(1, 4'd5, 1, 0);
    applyStimulus(2, 4'd6, 1, 0);
    applyStimulus(3, 4'd11, 1, 0);
    pushExp(EV_ACK, 0, t + 1, 0);
    pushExp(EV_DOOR, 0, t + 2, 15);
    pushExp(EV_ACK, 1, t + 19, 0);
    pushExp(EV_DOOR, 1, t + 20, 15);
    pushExp(EV_ACK, 2, t + 37, 0);
    pushExp(EV_DOOR, 2, t + 38, 15);
    pushExp(EV_ACK, 3, t + 55, 0);
    pushExp(EV_DOOR, 3, t + 56, 15);
    pushExp(EV_ACK, 0, t + 73, 0);
    pushExp(EV_DOOR, 0, t + 74, 15);
    waitCycle(t + 91);

    // Lane 1 arrives while lane 3's door is open
    $display("[TB] request during another lane's open window");
    stimSlot();
    t = cyc;
    applyStimulus(3, 4'd9, 1, 0);
    applyStimulus(1, 4'd10, 1, 4);
    pushExp(EV_ACK, 3, t + 1, 0);
    pushExp(EV_DOOR, 3, t + 2, 15);
    pushExp(EV_ACK, 1, t + 19, 0);
    pushExp(EV_DOOR, 1, t + 20, 15);
    waitCycle(t + 19);
    checkOutput("t5_grant_idx", int'(bus.grant_idx), 1);
    waitCycle(t + 37);

`ifdef METRO_LOCKOUT_EN
    // Lane 3 denied three times, locked out for 64 cycles while lane 1 runs
    $display("[TB] lockout after three denials");
    stimSlot();
    t = cyc;
    applyStimulus(3, 4'd2, 4, 0);
    applyStimulus(1, 4'd8, 1, 10);
    pushExp(EV_ACK, 3, t + 1, 0);
    pushExp(EV_DENY, 3, t + 2, 0);
    pushExp(EV_ACK, 3, t + 3, 0);
    pushExp(EV_DENY, 3, t + 4, 0);
    pushExp(EV_ACK, 3, t + 5, 0);
    pushExp(EV_DENY, 3, t + 6, 0);
    pushExp(EV_ACK, 1, t + 11, 0);
    pushExp(EV_DOOR, 1, t + 12, 15);
    pushExp(EV_ACK, 3, t + 71, 0);
    pushExp(EV_DENY, 3, t + 72, 0);
    waitCycle(t + 40);
    checkOutput("t6_locked_idle", int'(bus.state_out), 0);
    waitCycle(t + 73);
`endif

    waitCycle(cyc + 5);
    checkOutput("pending_events", expq.size(), 0);
    checkOutput("final_door", int'(bus.door_open), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/metro_gate_scheduler.md
# metro_gate_scheduler

Controller that shares one access-code validation and door-timing path among NUM_LANES turnstile lanes of a metro gate bank. Lanes raise requests carrying a 4-bit access code. A round-robin arbiter grants one lane at a time, validates the code, and either opens that lane's door for a fixed window or returns a denial. It sits between the per-lane card readers and the door actuators, and exports its state for station monitoring.

## Interface
- NUM_LANES, 4: number of requesting lanes (2..8).
- OPEN_CYCLES, 15: cycles a granted door stays open (>=1).
- CODE_LO, 4: lowest valid access code, inclusive.
- CODE_HI, 11: highest valid access code, inclusive.
- LOCKOUT_CYCLES, 64: lane lockout duration; used only with lockout compiled in.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- lane_req  input  NUM_LANES  per-lane request; held until lane_ack.
- lane_code  input  4*NUM_LANES  access code; lane k occupies bits [4k+3:4k].
- lane_ack  output  NUM_LANES  one-cycle pulse: request captured.
- lane_deny  output  NUM_LANES  one-cycle pulse: code rejected.
- door_open  output  NUM_LANES  door drive; at most one bit high.
- grant_idx  output  3  index of the lane currently or last served.
- state_out  output  2  current FSM state.

## Operation
- States: IDLE=2'b00, CHECK=2'b01, OPEN=2'b10, CLOSE=2'b11.
- IDLE:
  - If any eligible lane_req is high, pick lane k by round-robin, searching upward from pointer ptr with wrap.
  - Latch k into grant_idx and the 4-bit code into code_q, then go to CHECK.
  - No eligible request: stay in IDLE.
- CHECK, valid code (CODE_LO <= code_q <= CODE_HI, unsigned compare): go to OPEN and load timer with OPEN_CYCLES-1.
- CHECK, invalid code: go to IDLE.
- OPEN: decrement timer each cycle. At timer==0, go to CLOSE.
- CLOSE: one guard cycle with all doors closed, then IDLE.
- Illegal or unknown state: go to IDLE.
- Round-robin pointer: on every grant, ptr <= (k+1) mod NUM_LANES. Reset value of ptr is 0.
- Timer width is $clog2(OPEN_CYCLES+1). The timer never wraps.
- lane_req is sampled only in IDLE. Requests in any other state wait and are not lost while held.
- Simultaneous requests: exactly one lane is granted. Losers keep their request asserted and are served in round-robin order.
- A request withdrawn before its grant is simply not served.

## Timing
- Edge E0, state IDLE with lane_req[k]=1: state becomes CHECK, and lane_ack[k]=1 for that single CHECK cycle.
- Requester drops lane_req[k] at the edge that ends the ack cycle. A request still high at the next IDLE sample counts as a new request.
- Edge E1, valid code: state becomes OPEN and door_open[k]=1. Request-to-door latency is 2 cycles.
- Edge E1, invalid code: state becomes IDLE and lane_deny[k]=1 for one cycle.
- door_open[k] stays high for exactly OPEN_CYCLES cycles, followed by 1 CLOSE cycle.
- Earliest next grant:
  - After a denial: 2 cycles after ack.
  - After a grant: OPEN_CYCLES+3 cycles after ack.
- Reset values, applied asynchronously (any state, door closes immediately):
  - lane_ack, lane_deny, door_open = 0
  - grant_idx = 0, state_out = IDLE, ptr = 0, timer = 0

## Configuration
- METRO_LOCKOUT_EN defined:
  - Per-lane 2-bit consecutive-deny counter. A successful grant clears it.
  - The third consecutive deny on a lane starts a lockout of LOCKOUT_CYCLES for that lane.
  - During lockout the lane is ineligible for arbitration, and its lane_req gets no ack.
  - Lockout expiry clears the counter. Reset clears all counters and lockouts.
- METRO_LOCKOUT_EN undefined: no counters or lockout logic; every lane is always eligible.

## Structure
- Shared package metro_pkg holds:
  - State encodings IDLE/CHECK/OPEN/CLOSE as a 2-bit typedef.
  - CODE_W=4.
  - Default CODE_LO/CODE_HI window constants.
- One sub-module, metro_rr_arbiter:
  - Inputs: eligible request vector and ptr.
  - Outputs: grant one-hot, grant index, any_grant.
  - The pointer register stays in the parent.

## Test plan
- Lane 2 alone, code 7 -> ack[2] at cycle 1; door_open[2] high for cycles 2..16; CLOSE at 17; IDLE at 18.
- Lane 0, code 3 and code 12 -> ack[0], then deny[0] one cycle later; door_open stays 0; boundary codes 4 and 11 open the door.
- Lanes 0..3 all requesting continuously, valid codes -> grants in order 0,1,2,3,0; never two door bits high.
- Reset asserted mid-OPEN on lane 1 -> door_open drops in the same cycle without a clock edge; after release: state IDLE, ptr 0, lane 0 wins next.
- Request arriving during OPEN of another lane -> no ack until after CLOSE; served at the first IDLE sample.
- With METRO_LOCKOUT_EN, lane 3 denied 3 times -> ignored for 64 cycles while lane 1 is still served; after expiry, lane 3 is acked.
